// File: rtl/fetch_fill_ctrl.sv
// rtl/fetch_fill_ctrl.sv - I-cache block fill controller: issues eight word reads and writes the returned words plus the tag.
module fetch_fill_ctrl #(
   parameter int WORDS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   input  logic [15:0] memory_data,
   output logic        fsm_busy,
   output logic        memory_read,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic        write_tag_array,
   output logic [15:0] fill_address,
   output logic [15:0] memory_data_out
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);
   localparam logic [3:0] ALL_WORDS = 4'(WORDS);

   state_t      state;
   logic [15:0] base;
   logic [3:0]  issue_cnt;
   logic [3:0]  ret_cnt;
   logic        in_fill;
   logic        last_return;

   assign in_fill     = (state == FILL);
   assign last_return = in_fill && memory_data_valid && (ret_cnt == LAST_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         base      <= 16'h0000;
         issue_cnt <= 4'd0;
         ret_cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_detected) begin
                  base      <= miss_address & 16'hFFF0;
                  issue_cnt <= 4'd0;
                  ret_cnt   <= 4'd0;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (issue_cnt < ALL_WORDS)
                  issue_cnt <= issue_cnt + 4'd1;
               // Completion is driven purely by counted returns, so memory latency and gaps do not matter.
               if (memory_data_valid) begin
                  if (ret_cnt == LAST_WORD) begin
                     ret_cnt <= 4'd0;
                     state   <= IDLE;
                  end else begin
                     ret_cnt <= ret_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Busy follows the miss combinationally in IDLE so the PC stalls in the detection cycle.
   assign fsm_busy         = in_fill || miss_detected;
   assign memory_read      = in_fill && (issue_cnt < ALL_WORDS);
   assign memory_address   = base + {12'd0, issue_cnt[2:0], 1'b0};
   assign write_data_array = in_fill && memory_data_valid;
   assign write_tag_array  = last_return;
   assign fill_address     = base + {12'd0, ret_cnt[2:0], 1'b0};
   assign memory_data_out  = memory_data;

endmodule

// File: tb/tb_fetch_fill_ctrl.sv
// tb/tb_fetch_fill_ctrl.sv - randomized self-checking bench for fetch_fill_ctrl against a block-fill reference model.
module tb_fetch_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0000;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data = 16'h0000;
   logic        fsm_busy;
   logic        memory_read;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic        write_tag_array;
   logic [15:0] fill_address;
   logic [15:0] memory_data_out;

   int passed = 0;
   int total = 0;

   fetch_fill_ctrl #(.WORDS(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .memory_read       (memory_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .write_tag_array   (write_tag_array),
      .fill_address      (fill_address),
      .memory_data_out   (memory_data_out)
   );

   always #5 clk = ~clk;

   // Model: the block base is the miss address with the byte offset cleared; read i goes out in cycle i+1
   // after the miss, and the k-th returned word lands at base + 2k, with the tag written alongside word 7.
   task automatic run_fill(input logic [15:0] addr, input bit irregular, input int n_writes);
      logic [15:0] blk;
      logic [15:0] d[8];
      int          vcyc[8];
      int          k;
      int          prev;
      bit          v;
      blk  = addr & 16'hFFF0;
      prev = 1;
      for (int i = 0; i < 8; i++) begin
         if (irregular) begin
            vcyc[i] = prev + 1 + int'($urandom_range(0, 3));
            d[i]    = 16'($urandom);
         end else begin
            vcyc[i] = 5 + i;
            d[i]    = 16'hA000 + 16'(i);
         end
         prev = vcyc[i];
      end
      @(posedge clk); #1;
      miss_detected     = 1'b1;
      miss_address      = addr;
      memory_data_valid = 1'b0;
      @(negedge clk);
      total++; if (fsm_busy !== 1'b1) $display("FAIL busy_c0: got %b expected 1", fsm_busy); else passed++;
      total++; if (memory_read !== 1'b0) $display("FAIL read_c0: got %b expected 0", memory_read); else passed++;
      k = 0;
      for (int c = 1; c <= vcyc[n_writes-1]; c++) begin
         @(posedge clk); #1;
         miss_address      = 16'($urandom);
         v                 = (c == vcyc[k]);
         memory_data_valid = v;
         memory_data       = v ? d[k] : 16'($urandom);
         @(negedge clk);
         total++; if (fsm_busy !== 1'b1) $display("FAIL busy c%0d: got %b expected 1", c, fsm_busy); else passed++;
         total++; if (memory_read !== (c <= 8)) $display("FAIL read c%0d: got %b expected %b", c, memory_read, (c <= 8)); else passed++;
         if (c <= 8) begin
            total++;
            if (memory_address !== blk + 16'(2 * (c - 1)))
               $display("FAIL raddr c%0d: got %h expected %h", c, memory_address, blk + 16'(2 * (c - 1)));
            else passed++;
         end
         total++; if (write_data_array !== v) $display("FAIL wda c%0d: got %b expected %b", c, write_data_array, v); else passed++;
         total++; if (write_tag_array !== (v && k == 7)) $display("FAIL tag c%0d: got %b expected %b", c, write_tag_array, (v && k == 7)); else passed++;
         if (v) begin
            total++;
            if (fill_address !== blk + 16'(2 * k)) $display("FAIL faddr w%0d: got %h expected %h", k, fill_address, blk + 16'(2 * k));
            else passed++;
            total++;
            if (memory_data_out !== d[k]) $display("FAIL wdata w%0d: got %h expected %h", k, memory_data_out, d[k]);
            else passed++;
            k++;
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         miss_detected     = 1'($urandom);
         miss_address      = 16'($urandom);
         memory_data_valid = (i < 4) ? 1'b1 : 1'($urandom);
         memory_data       = 16'($urandom);
         @(negedge clk);
         total++; if (fsm_busy !== miss_detected) $display("FAIL rst_busy: got %b expected %b", fsm_busy, miss_detected); else passed++;
         total++; if (memory_read !== 1'b0) $display("FAIL rst_read: got %b expected 0", memory_read); else passed++;
         total++; if (write_data_array !== 1'b0) $display("FAIL rst_wda: got %b expected 0", write_data_array); else passed++;
         total++; if (write_tag_array !== 1'b0) $display("FAIL rst_tag: got %b expected 0", write_tag_array); else passed++;
         total++; if (memory_address !== 16'h0) $display("FAIL rst_raddr: got %h expected 0000", memory_address); else passed++;
         total++; if (fill_address !== 16'h0) $display("FAIL rst_faddr: got %h expected 0000", fill_address); else passed++;
      end
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_spurious_valid();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         miss_detected     = 1'b0;
         miss_address      = 16'($urandom);
         memory_data_valid = 1'b1;
         memory_data       = 16'($urandom);
         @(negedge clk);
         total++; if (fsm_busy !== 1'b0) $display("FAIL spur_busy: got %b expected 0", fsm_busy); else passed++;
         total++; if (write_data_array !== 1'b0) $display("FAIL spur_wda: got %b expected 0", write_data_array); else passed++;
         total++; if (write_tag_array !== 1'b0) $display("FAIL spur_tag: got %b expected 0", write_tag_array); else passed++;
         total++; if (memory_read !== 1'b0) $display("FAIL spur_read: got %b expected 0", memory_read); else passed++;
      end
   endtask

   task automatic end_fill(input string name);
      @(posedge clk); #1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      @(negedge clk);
      total++; if (fsm_busy !== 1'b0) $display("FAIL %s_idle_busy: got %b expected 0", name, fsm_busy); else passed++;
      total++; if (write_data_array !== 1'b0) $display("FAIL %s_idle_wda: got %b expected 0", name, write_data_array); else passed++;
      memory_data_valid = 1'b0;
   endtask

   task automatic test_nominal_fill();
      run_fill(16'h1234, 1'b0, 8);
      end_fill("nominal");
   endtask

   task automatic test_irregular_returns();
      for (int n = 0; n < 4; n++) begin
         run_fill(16'($urandom), 1'b1, 8);
         end_fill("irregular");
      end
   endtask

   task automatic test_reset_mid_fill();
      run_fill(16'($urandom), 1'b0, 3);
      @(posedge clk); #1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      rst_n             = 1'b0;
      #1;
      total++; if (fsm_busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", fsm_busy); else passed++;
      total++; if (memory_read !== 1'b0) $display("FAIL mid_read: got %b expected 0", memory_read); else passed++;
      total++; if (write_data_array !== 1'b0) $display("FAIL mid_wda: got %b expected 0", write_data_array); else passed++;
      total++; if (write_tag_array !== 1'b0) $display("FAIL mid_tag: got %b expected 0", write_tag_array); else passed++;
      total++; if (memory_address !== 16'h0) $display("FAIL mid_raddr: got %h expected 0000", memory_address); else passed++;
      total++; if (fill_address !== 16'h0) $display("FAIL mid_faddr: got %h expected 0000", fill_address); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int w = 3; w < 8; w++) begin
         @(posedge clk); #1;
         memory_data_valid = 1'b1;
         memory_data       = 16'($urandom);
         @(negedge clk);
         total++; if (write_data_array !== 1'b0) $display("FAIL post_wda w%0d: got %b expected 0", w, write_data_array); else passed++;
         total++; if (write_tag_array !== 1'b0) $display("FAIL post_tag w%0d: got %b expected 0", w, write_tag_array); else passed++;
         total++; if (fsm_busy !== 1'b0) $display("FAIL post_busy w%0d: got %b expected 0", w, fsm_busy); else passed++;
         memory_data_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      run_fill(16'hFFFE, 1'b0, 8);
      run_fill(16'h0010, 1'b1, 8);
      end_fill("b2b");
   endtask

   initial begin
      test_reset();
      test_spurious_valid();
      test_nominal_fill();
      test_irregular_returns();
      test_reset_mid_fill();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_fill_ctrl.md
# fetch_fill_ctrl

Cache-fill controller for the instruction-fetch side of the 16-bit pipelined CPU. It sits between the instruction cache and the multi-cycle main memory. On an I-cache miss at the current PC, it fetches the 16-byte block containing that address as eight 16-bit words and drives the data-array and tag-array writes. While the fill is in progress it holds `fsm_busy` high so the fetch stage and PC stall.

## Interface
Parameters:
- `WORDS`, 8, words per cache block; fixed at 8 (16-byte block, 2-byte words).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `miss_detected`  in  1  I-cache tag miss for `miss_address`; held by the cache until the fill completes.
- `miss_address`  in  16  faulting fetch address (the PC).
- `memory_data_valid`  in  1  main memory returns one word this cycle.
- `memory_data`  in  16  word returned by main memory.
- `fsm_busy`  out  1  fill in progress; stalls PC and fetch.
- `memory_read`  out  1  read request to main memory this cycle.
- `memory_address`  out  16  address of the current read request.
- `write_data_array`  out  1  write `memory_data_out` into the data array this cycle.
- `write_tag_array`  out  1  write the tag and set valid for `fill_address` this cycle.
- `fill_address`  out  16  byte address of the word being written to the data array.
- `memory_data_out`  out  16  word to write; equals `memory_data`, combinational passthrough.

## Operation
- States: IDLE, FILL. Internal registers: `base[15:0]`, `issue_cnt[3:0]`, `ret_cnt[3:0]`.
- IDLE:
  - `fsm_busy = miss_detected`, combinational, so the stall applies in the same cycle the miss is detected.
  - On `miss_detected`: latch `base = miss_address & 16'hFFF0`, clear both counters, move to FILL.
  - `memory_data_valid` in IDLE is ignored: no array writes.
- FILL:
  - `fsm_busy = 1`.
  - Address issue:
    - `memory_read = (issue_cnt < 8)`.
    - `memory_address = base + {issue_cnt[2:0], 1'b0}`.
    - `issue_cnt` increments each cycle while it is below 8, then saturates at 8.
  - Data return: on each `memory_data_valid`:
    - `write_data_array = 1`.
    - `fill_address = base + {ret_cnt[2:0], 1'b0}`.
    - `ret_cnt` increments.
  - Completion: when `memory_data_valid` and `ret_cnt == 7`:
    - `write_tag_array = 1` in the same cycle as the last data write.
    - Next state is IDLE and `ret_cnt` clears.
  - `miss_detected` and `miss_address` are ignored; `base` is stable for the whole fill.
- Outside the cases above, `write_data_array`, `write_tag_array` and `memory_read` are 0. `memory_address` and `fill_address` show the `base`-derived value and are don't-care while their strobes are low.
- Word ordering: the fill always starts at word 0 of the block; there is no critical-word-first.
- Arithmetic: the offsets add into bits [3:1] only. `base[3:0] = 0`, so there is no carry and no wrap past the block.
- The controller counts data returns and does not rely on the memory latency. Gaps between valids are tolerated.

## Timing
- Reset, asynchronous, while `rst_n` is low:
  - State IDLE; `base`, `issue_cnt` and `ret_cnt` are 0.
  - `fsm_busy`, `memory_read`, `write_data_array` and `write_tag_array` are 0, provided `miss_detected` is 0.
  - `memory_address` and `fill_address` are 0.
- Reset during FILL aborts the fill immediately. No tag write occurs. Valids arriving after release are ignored in IDLE.
- Nominal fill with 4-cycle memory latency:
  - Miss at cycle 0 (busy already high).
  - Reads issued in cycles 1–8.
  - Data writes in cycles 5–12; tag write in cycle 12.
  - IDLE in cycle 13 with `fsm_busy` low, unless the miss is still asserted.
- Back-to-back: a new `miss_detected` in the first IDLE cycle after completion starts a new fill on the next edge. Busy stays high continuously.
- The cache must lower `miss_detected` by the cycle after the tag write, otherwise a redundant refill starts.

## Test plan
- Reset: hold `rst_n = 0` with random inputs, including `memory_data_valid = 1` -> all strobes 0, both addresses 0, `fsm_busy` equals `miss_detected`. No array write.
- Nominal fill: `miss_address = 0x1234`, memory returns data `0xA000+i` 4 cycles after each read, `miss_detected` dropped after the tag write:
  - `memory_address` = 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - Writes to `fill_address` 0x1230–0x123E carry data 0xA000–0xA007.
  - `write_tag_array` is high only in cycle 12; `fsm_busy` falls in cycle 13.
- Irregular returns: valids with 0–3 idle cycles between them -> exactly 8 data writes in order, tag write on the 8th, then IDLE.
- Spurious valid: `memory_data_valid = 1` in IDLE with no miss -> no `write_data_array`, no `write_tag_array`, `fsm_busy = 0`.
- Reset mid-fill: deassert `rst_n` after the third data write -> outputs clear asynchronously. After release, remaining valids cause no writes and there is no tag write.
- Back-to-back: miss at 0xFFFE, then a miss at 0x0010 right after completion:
  - First fill reads and writes 0xFFF0–0xFFFE with no wrap.
  - Second fill covers 0x0010–0x001E.
  - `fsm_busy` never drops between the two fills.
